// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch unit and its decode neighbour.
// This covers the FSM state encoding, the default HLT opcode and the instruction length rule.
package fetch_pkg;

  // The state encoding is kept as plain constants so that older decode code can compare against it.
  localparam logic [1:0] FETCH_OP  = 2'd0;
  localparam logic [1:0] FETCH_IMM = 2'd1;
  localparam logic [1:0] HOLD      = 2'd2;
  localparam logic [1:0] HALTED    = 2'd3;

  localparam logic [7:0] HLT_OPCODE_DEFAULT = 8'h76;

  // Opcodes with the top bit set carry one immediate byte after them.
  function automatic logic is_two_byte(input logic [7:0] opcode);
    return opcode[7];
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction handoff channel from the fetch unit to the decoder.
// The fetch unit is the master and presents the instruction. The decoder is the slave and accepts it.
interface fetch_unit_if #(
  parameter int ADDR_W = 8
);
  logic              instr_valid;
  logic              instr_ready;
  logic [7:0]        instr_opcode;
  logic [7:0]        instr_operand;
  logic              instr_len2;
  logic [ADDR_W-1:0] instr_pc;

  modport master (
    output instr_valid, instr_opcode, instr_operand, instr_len2, instr_pc,
    input  instr_ready
  );

  modport slave (
    input  instr_valid, instr_opcode, instr_operand, instr_len2, instr_pc,
    output instr_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Fetch unit: reads 1- or 2-byte instructions from the 8-bit program memory.
// It hands each instruction to the decoder, follows redirects from execute and stops after HLT.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W     = 8,
  parameter logic [ADDR_W-1:0] RESET_PC   = 8'h02,
  parameter logic [7:0]        HLT_OPCODE = HLT_OPCODE_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] mem_address,
  input  logic [7:0]        mem_data,
  fetch_unit_if.master      ibus,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              halted
);

  logic [ADDR_W-1:0] pc;
  logic [1:0]        state;

  // The memory is addressed straight from the PC register, so read data belongs to the current PC.
  assign mem_address = pc;

  // The FSM and the instruction registers share one synchronous active-low reset.
  // Priority order: reset, then redirect, then normal sequencing.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc                 <= RESET_PC;
      state              <= FETCH_OP;
      ibus.instr_valid   <= 1'b0;
      ibus.instr_opcode  <= 8'h00;
      ibus.instr_operand <= 8'h00;
      ibus.instr_len2    <= 1'b0;
      ibus.instr_pc      <= '0;
      halted             <= 1'b0;
    end else if (redirect_valid) begin
      // A redirect drops any partial or pending instruction. A handshake in this same
      // cycle has already completed on the decoder side, so clearing valid is correct.
      pc               <= redirect_addr;
      state            <= FETCH_OP;
      ibus.instr_valid <= 1'b0;
      halted           <= 1'b0;
    end else begin
      case (state)
        FETCH_OP: begin
          // NOTE: non-blocking assignments make every register here see the pre-edge pc.
          // A blocking pc update would corrupt instr_pc.
          ibus.instr_opcode <= mem_data;
          ibus.instr_pc     <= pc;
          pc                <= pc + ADDR_W'(1);
          if (is_two_byte(mem_data)) begin
            state <= FETCH_IMM;
          end else begin
            ibus.instr_operand <= 8'h00;
            ibus.instr_len2    <= 1'b0;
            ibus.instr_valid   <= 1'b1;
            state              <= HOLD;
          end
        end
        FETCH_IMM: begin
          ibus.instr_operand <= mem_data;
          ibus.instr_len2    <= 1'b1;
          ibus.instr_valid   <= 1'b1;
          pc                 <= pc + ADDR_W'(1);
          state              <= HOLD;
        end
        HOLD: begin
          // Everything is frozen until the decoder takes the instruction.
          if (ibus.instr_ready) begin
            ibus.instr_valid <= 1'b0;
            if (ibus.instr_opcode == HLT_OPCODE) begin
              state  <= HALTED;
              halted <= 1'b1;
            end else begin
              state <= FETCH_OP;
            end
          end
        end
        HALTED: begin
          // The PC stays one past the HLT until a redirect or a reset.
        end
        default: state <= FETCH_OP;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit.
// A 256-byte array with a combinational read port models program memory.
module tb_fetch_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] mem_address;
  logic [7:0] mem_data;
  logic       redirect_valid;
  logic [7:0] redirect_addr;
  logic       halted;
  logic [7:0] mem [256];

  int n_tests = 0;
  int n_fail  = 0;

  fetch_unit_if #(.ADDR_W(8)) ibus ();

  fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .mem_address   (mem_address),
    .mem_data      (mem_data),
    .ibus          (ibus),
    .redirect_valid(redirect_valid),
    .redirect_addr (redirect_addr),
    .halted        (halted)
  );

  assign mem_data = mem[mem_address];

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge and sample just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset          = 1'b0;
    redirect_valid = 1'b0;
    redirect_addr  = 8'h00;
    tick();
    tick();
    reset = 1'b1;
  endtask

  // Wait (bounded) for the next presented instruction and compare all of its fields.
  task automatic expect_instr(input string tag, input logic [7:0] op, input logic [7:0] opd,
                              input logic len2, input logic [7:0] pc);
    int n = 0;
    tick();
    while (!ibus.instr_valid && n < 12) begin
      tick();
      n++;
    end
    check({tag, "_valid"},   ibus.instr_valid, 1);
    check({tag, "_opcode"},  ibus.instr_opcode, op);
    check({tag, "_operand"}, ibus.instr_operand, opd);
    check({tag, "_len2"},    ibus.instr_len2, len2);
    check({tag, "_pc"},      ibus.instr_pc, pc);
  endtask

  task automatic load_program();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h02] = 8'h80; mem[8'h03] = 8'h01;
    mem[8'h04] = 8'h81; mem[8'h05] = 8'h01;
    mem[8'h06] = 8'h82; mem[8'h07] = 8'h08;
    mem[8'h08] = 8'h41; mem[8'h09] = 8'h44;
    mem[8'h0A] = 8'h92; mem[8'h0B] = 8'h00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    load_program();
    ibus.instr_ready = 1'b1;

    // Reset values.
    do_reset();
    reset = 1'b0;
    check("rst_valid",   ibus.instr_valid, 0);
    check("rst_addr",    mem_address, 8'h02);
    check("rst_halted",  halted, 0);
    check("rst_opcode",  ibus.instr_opcode, 0);
    check("rst_operand", ibus.instr_operand, 0);
    check("rst_len2",    ibus.instr_len2, 0);
    check("rst_pc",      ibus.instr_pc, 0);
    reset = 1'b1;

    // Straight-line program: the first valid appears exactly 2 edges after release.
    tick();
    check("lat_edge1_valid", ibus.instr_valid, 0);
    tick();
    check("lat_edge2_valid", ibus.instr_valid, 1);
    check("seq0_opcode",  ibus.instr_opcode, 8'h80);
    check("seq0_operand", ibus.instr_operand, 8'h01);
    check("seq0_len2",    ibus.instr_len2, 1);
    check("seq0_pc",      ibus.instr_pc, 8'h02);
    expect_instr("seq1", 8'h81, 8'h01, 1'b1, 8'h04);
    expect_instr("seq2", 8'h82, 8'h08, 1'b1, 8'h06);
    expect_instr("seq3", 8'h41, 8'h00, 1'b0, 8'h08);
    expect_instr("seq4", 8'h44, 8'h00, 1'b0, 8'h09);
    expect_instr("seq5", 8'h92, 8'h00, 1'b1, 8'h0A);

    // Backpressure: the instruction is held stable and no extra fetch happens.
    ibus.instr_ready = 1'b0;
    do_reset();
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid",   ibus.instr_valid, 1);
      check("bp_opcode",  ibus.instr_opcode, 8'h80);
      check("bp_operand", ibus.instr_operand, 8'h01);
      check("bp_len2",    ibus.instr_len2, 1);
      check("bp_pc",      ibus.instr_pc, 8'h02);
      check("bp_addr",    mem_address, 8'h04);
    end
    ibus.instr_ready = 1'b1;
    tick();
    check("bp_accept_valid", ibus.instr_valid, 0);
    check("bp_accept_addr",  mem_address, 8'h04);
    expect_instr("bp_next", 8'h81, 8'h01, 1'b1, 8'h04);

    // HLT at 08: the instruction is handed off, then the unit halts with the address held at 09.
    mem[8'h08] = 8'h76;
    do_reset();
    expect_instr("hlt_i0", 8'h80, 8'h01, 1'b1, 8'h02);
    expect_instr("hlt_i1", 8'h81, 8'h01, 1'b1, 8'h04);
    expect_instr("hlt_i2", 8'h82, 8'h08, 1'b1, 8'h06);
    expect_instr("hlt_op", 8'h76, 8'h00, 1'b0, 8'h08);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("hlt_halted", halted, 1);
      check("hlt_addr",   mem_address, 8'h09);
      check("hlt_valid",  ibus.instr_valid, 0);
    end
    redirect_valid = 1'b1;
    redirect_addr  = 8'h02;
    tick();
    redirect_valid = 1'b0;
    check("hlt_redir_halted", halted, 0);
    check("hlt_redir_addr",   mem_address, 8'h02);
    expect_instr("hlt_refetch", 8'h80, 8'h01, 1'b1, 8'h02);

    // A redirect in the same cycle as an accepted HLT wins over halting.
    do_reset();
    expect_instr("hr_i0", 8'h80, 8'h01, 1'b1, 8'h02);
    expect_instr("hr_i1", 8'h81, 8'h01, 1'b1, 8'h04);
    expect_instr("hr_i2", 8'h82, 8'h08, 1'b1, 8'h06);
    expect_instr("hr_hlt", 8'h76, 8'h00, 1'b0, 8'h08);
    redirect_valid = 1'b1;
    redirect_addr  = 8'h02;
    tick();
    redirect_valid = 1'b0;
    check("hr_halted", halted, 0);
    check("hr_valid",  ibus.instr_valid, 0);
    check("hr_addr",   mem_address, 8'h02);
    expect_instr("hr_next", 8'h80, 8'h01, 1'b1, 8'h02);
    mem[8'h08] = 8'h41;

    // Redirect during FETCH_IMM of 80@02 discards it.
    do_reset();
    tick();
    redirect_valid = 1'b1;
    redirect_addr  = 8'h08;
    tick();
    redirect_valid = 1'b0;
    check("mid_valid", ibus.instr_valid, 0);
    check("mid_addr",  mem_address, 8'h08);
    expect_instr("mid_next", 8'h41, 8'h00, 1'b0, 8'h08);

    // Wrap-around: 80 at FF takes its operand from 00.
    mem[8'hFF] = 8'h80;
    mem[8'h00] = 8'h55;
    do_reset();
    redirect_valid = 1'b1;
    redirect_addr  = 8'hFF;
    tick();
    redirect_valid = 1'b0;
    check("wrap_addr_ff", mem_address, 8'hFF);
    expect_instr("wrap", 8'h80, 8'h55, 1'b1, 8'hFF);
    check("wrap_addr_01", mem_address, 8'h01);
    expect_instr("wrap_next", 8'h00, 8'h00, 1'b0, 8'h01);

    // Reset while an instruction is pending in HOLD.
    ibus.instr_ready = 1'b0;
    do_reset();
    tick();
    tick();
    check("rh_pre_valid", ibus.instr_valid, 1);
    reset = 1'b0;
    tick();
    check("rh_valid",  ibus.instr_valid, 0);
    check("rh_addr",   mem_address, 8'h02);
    check("rh_opcode", ibus.instr_opcode, 0);
    reset = 1'b1;
    ibus.instr_ready = 1'b1;
    expect_instr("rh_first", 8'h80, 8'h01, 1'b1, 8'h02);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Bus initiator for the 8-bit program memory. Drives `mem_address` and samples the combinational `mem_data` read port.
- Assembles 1- or 2-byte instructions and hands each one to the decoder over a valid/ready handshake.
- Sits between program memory and the decode/execute stage. Accepts PC redirects (jumps) from execute and stops fetching after HLT.

Parameters:
- RESET_PC, 8'h02, program counter value loaded on reset.
- HLT_OPCODE, 8'h76, opcode that halts fetching once it has been handed off.
- ADDR_W, 8, address width. Memory depth is 2**ADDR_W and is fixed at 256 in this design.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- reset  input  1  reset, synchronous and active-low; sampled on the clk rising edge.
- mem_address  output  8  program memory address; equals the PC register.
- mem_data  input  8  program memory read data; combinational from mem_address.
- instr_valid  output  1  a complete instruction is present on the instr_* outputs.
- instr_ready  input  1  the decoder accepts the instruction this cycle.
- instr_opcode  output  8  opcode byte.
- instr_operand  output  8  immediate byte; 8'h00 for 1-byte instructions.
- instr_len2  output  1  1 = 2-byte instruction, 0 = 1-byte instruction.
- instr_pc  output  8  address of the opcode byte.
- redirect_valid  input  1  load a new PC (jump or branch taken).
- redirect_addr  input  8  new PC value.
- halted  output  1  fetching is stopped after HLT was accepted.

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset (reset==0 at an edge) loads the following:
  - pc = RESET_PC, state = FETCH_OP.
  - instr_valid = 0, instr_opcode = 0, instr_operand = 0, instr_len2 = 0, instr_pc = 0, halted = 0.
- mem_address = pc at all times (combinational). pc increments modulo 256, so 8'hFF wraps to 8'h00.
- Length rule: opcode[7]==1 gives a 2-byte instruction; opcode[7]==0 gives a 1-byte instruction.
- States:
  - FETCH_OP:
    - At the edge: instr_opcode <= mem_data, instr_pc <= pc, pc <= pc+1.
    - If the instruction is 2-byte, go to FETCH_IMM.
    - Otherwise: instr_operand <= 0, instr_len2 <= 0, instr_valid <= 1, go to HOLD.
  - FETCH_IMM:
    - At the edge: instr_operand <= mem_data, instr_len2 <= 1, pc <= pc+1, instr_valid <= 1, go to HOLD.
  - HOLD:
    - Outputs stay stable while instr_valid && !instr_ready.
    - On instr_ready: instr_valid <= 0.
    - Next state is HALTED if instr_opcode == HLT_OPCODE, else FETCH_OP.
  - HALTED:
    - halted = 1; pc is frozen at the HLT address + 1.
    - No instr_valid is produced. Exit only through redirect or reset.
- Latency, counted from the edge that enters FETCH_OP:
  - 1-byte instruction: instr_valid rises after 1 edge.
  - 2-byte instruction: instr_valid rises after 2 edges.
  - After acceptance, the next FETCH_OP begins one cycle later. Peak throughput is 1 instruction per 2 cycles (1-byte) or per 3 cycles (2-byte).
- Redirect, in any state:
  - Action at the edge: pc <= redirect_addr, state <= FETCH_OP, instr_valid <= 0, halted <= 0.
  - Any partially fetched instruction is discarded.
  - Redirect in the same cycle as instr_valid && instr_ready: the handshake counts as a completed transfer, and the redirect still applies.
  - A redirect in the same cycle as an accepted HLT wins: the unit goes to FETCH_OP, not HALTED.
- Reset has priority over redirect and handshake. Reset asserted mid-instruction discards all in-flight state.
- A 2-byte opcode at 8'hFF fetches its operand from 8'h00 (wrap-around).

Decomposition:
- Shared package fetch_pkg holds:
  - the state encoding FETCH_OP / FETCH_IMM / HOLD / HALTED;
  - the HLT_OPCODE default;
  - an is_two_byte(opcode) function, so decode uses the same length rule.
- No sub-module; the block is one FSM plus datapath registers.
- The bench instantiates the existing program memory, preloaded as the memory model.

Test Plan:
- Memory preloaded 02:80 03:01 04:81 05:01 06:82 07:08 08:41 09:44 0A:92 0B:00; instr_ready held at 1; release reset. Required sequence:
  - (80,01,pc02,len2);
  - (81,01,pc04);
  - (82,08,pc06);
  - (41,00,pc08,len1);
  - (44,pc09);
  - (92,00,pc0A);
  - the first instr_valid appears 2 edges after reset release.
- Backpressure: instr_ready=0 for 5 cycles on (80,01). instr_valid and all fields must stay stable; mem_address stays 04 with no extra fetch; the instruction is accepted once ready rises.
- HLT: byte 76 at 08 → instruction (76,pc08,len1) is handed off, then halted=1 and mem_address=09 is held indefinitely. A redirect to 02 clears halted and refetches 80.
- Redirect mid-fetch: assert redirect_valid (addr 08) during FETCH_IMM of 80@02. The 80 is never presented; the next instruction is (41,pc08).
- Wrap: byte 80 at FF and 55 at 00, with redirect to FF → instruction (80,55,pcFF,len2); the next fetch is at 01.
- Reset mid-HOLD: reset=0 while instr_valid=1 → next cycle instr_valid=0 and mem_address=02. After release, the first instruction is (80,01,pc02).
